// File: rtl/seq_alu_pkg.sv
// seq_alu shared definitions: opcodes, FSM state, counter width.
// Build option SEQ_ALU_SIGNED_MULT_EN selects two's complement MULT.
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MULT = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  typedef enum logic {
    IDLE,
    MUL
  } state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Radix-2 shift-add multiplier datapath, one multiplier bit per clock.
// SEQ_ALU_SIGNED_MULT_EN: sign-extended sum, subtract on last step.
module seq_alu_mul
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic               last,
  output logic [2*WIDTH-1:0] prod_next
);

  localparam int CW = cnt_w(WIDTH);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     ext_hi, ext_mc, sum;

  assign last = (cnt_q == CW'(WIDTH - 1));

`ifdef SEQ_ALU_SIGNED_MULT_EN
  assign ext_hi = {acc_q[2*WIDTH-1], acc_q[2*WIDTH-1:WIDTH]};
  assign ext_mc = {mcand_q[WIDTH-1], mcand_q};
`else
  assign ext_hi = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  assign ext_mc = {1'b0, mcand_q};
`endif

  always_comb begin
    sum = ext_hi;
    if (acc_q[0]) begin
`ifdef SEQ_ALU_SIGNED_MULT_EN
      // the top multiplier bit carries negative weight
      sum = last ? (ext_hi - ext_mc) : (ext_hi + ext_mc);
`else
      sum = ext_hi + ext_mc;
`endif
    end
  end

  // sum[WIDTH] enters at the top: carry or sign bit
  assign prod_next = {sum, acc_q[WIDTH-1:1]};

  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (load) begin
      mcand_d = mcand_in;
      acc_d   = {{WIDTH{1'b0}}, mplier_in};
      cnt_d   = '0;
    end else if (step) begin
      acc_d = prod_next;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle ops plus iterative MULT.
// Build option SEQ_ALU_SIGNED_MULT_EN selects two's complement MULT.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             zero
);

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [WIDTH-1:0]   out_hi_q, out_hi_d;
  logic               accept, load, step, last;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH:0]     alu;

  assign accept = start && (state_q == IDLE);
  assign load   = accept && (op == OP_MULT);
  assign step   = (state_q == MUL);

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .load      (load),
    .step      (step),
    .mcand_in  (inp1),
    .mplier_in (inp2),
    .last      (last),
    .prod_next (prod_next)
  );

  // bit WIDTH is carry/borrow for ADD/SUB, zero otherwise
  always_comb begin
    alu = '0;
    unique case (op)
      OP_ADD:  alu = {1'b0, inp1} + {1'b0, inp2};
      OP_SUB:  alu = {1'b0, inp1} - {1'b0, inp2};
      OP_MULT: alu = '0;
      OP_AND:  alu = {1'b0, inp1 & inp2};
      OP_OR:   alu = {1'b0, inp1 | inp2};
      OP_NAND: alu = {1'b0, ~(inp1 & inp2)};
      OP_NOR:  alu = {1'b0, ~(inp1 | inp2)};
      OP_XOR:  alu = {1'b0, inp1 ^ inp2};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    out_d    = out_q;
    out_hi_d = out_hi_q;
    zero_d   = zero_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = MUL;
          busy_d  = 1'b1;
        end else if (accept) begin
          out_d    = alu[WIDTH-1:0];
          out_hi_d = {{(WIDTH-1){1'b0}}, alu[WIDTH]};
          zero_d   = (alu[WIDTH-1:0] == '0);
          done_d   = 1'b1;
        end
      end
      MUL: begin
        if (last) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          out_d    = prod_next[WIDTH-1:0];
          out_hi_d = prod_next[2*WIDTH-1:WIDTH];
          zero_d   = (prod_next == '0);
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      out_q    <= '0;
      out_hi_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign out    = out_q;
  assign out_hi = out_hi_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: vector table, random ops, corner sequences.
// Honours SEQ_ALU_SIGNED_MULT_EN for expected MULT results.
`timescale 1ns/1ps
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b0;
  logic [W-1:0] inp1 = '0, inp2 = '0;
  logic         busy, done, zero;
  logic [W-1:0] out, out_hi;

  logic         s8_start = 1'b0;
  logic [2:0]   s8_op = 3'b0;
  logic [7:0]   s8_a = '0, s8_b = '0;
  logic         s8_busy, s8_done, s8_zero;
  logic [7:0]   s8_out, s8_hi;

  int n_pass = 0;
  int n_total = 0;

  seq_alu #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .op(op),
    .inp1(inp1), .inp2(inp2), .busy(busy), .done(done),
    .out(out), .out_hi(out_hi), .zero(zero)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RST_N(RST_N), .start(s8_start), .op(s8_op),
    .inp1(s8_a), .inp2(s8_b), .busy(s8_busy), .done(s8_done),
    .out(s8_out), .out_hi(s8_hi), .zero(s8_zero)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, got, exp);
  endtask

  // {hi,lo} for an n-bit ALU, straight from the arithmetic definitions
  function automatic logic [63:0] ref_res(input logic [2:0] o, input int n,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
    logic [63:0] m, r;
    longint sa, sb;
    m  = (64'd1 << n) - 64'd1;
    sa = longint'(a) - (a[n-1] ? longint'(64'd1 << n) : 64'sd0);
    sb = longint'(b) - (b[n-1] ? longint'(64'd1 << n) : 64'sd0);
    case (o)
      OP_ADD:  r = a + b;
      OP_SUB:  r = ((a - b) & m) | ((a < b) ? (64'd1 << n) : 64'd0);
`ifdef SEQ_ALU_SIGNED_MULT_EN
      OP_MULT: begin
        r = sa * sb;
        if (n < 32) r = r & ((64'd1 << (2 * n)) - 64'd1);
      end
`else
      OP_MULT: r = a * b;
`endif
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b) & m;
      OP_NOR:  r = ~(a | b) & m;
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  task automatic run32(input string nm, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] elo, input logic [31:0] ehi,
                       input logic ez);
    int n;
    start = 1'b1; op = o; inp1 = a; inp2 = b;
    @(posedge CLK); #1;
    start = 1'b0; op = 3'($urandom); inp1 = $urandom; inp2 = $urandom;
    chk({nm, "/busy"}, busy, (o == OP_MULT));
    n = 1;
    while (!done && n < W + 8) begin
      @(posedge CLK); #1;
      n++;
    end
    chk({nm, "/lat"}, n, (o == OP_MULT) ? W + 1 : 1);
    chk({nm, "/lo"}, out, elo);
    chk({nm, "/hi"}, out_hi, ehi);
    chk({nm, "/zero"}, zero, ez);
    @(posedge CLK); #1;
    chk({nm, "/pulse"}, {busy, done}, 2'b00);
  endtask

  task automatic run32m(input string nm, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    logic ez;
    r  = ref_res(o, 32, {32'd0, a}, {32'd0, b});
    ez = (o == OP_MULT) ? (r == 64'd0) : (r[31:0] == 32'd0);
    run32(nm, o, a, b, r[31:0], r[63:32], ez);
  endtask

  task automatic run8(input string nm, input logic [2:0] o,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp);
    int n;
    s8_start = 1'b1; s8_op = o; s8_a = a; s8_b = b;
    @(posedge CLK); #1;
    s8_start = 1'b0; s8_b = 8'($urandom);
    n = 1;
    while (!s8_done && n < 16) begin
      @(posedge CLK); #1;
      n++;
    end
    chk({nm, "/lat"}, n, (o == OP_MULT) ? 9 : 1);
    chk({nm, "/res"}, {s8_hi, s8_out}, exp);
    chk({nm, "/zero"}, s8_zero,
        (o == OP_MULT) ? (exp == 16'd0) : (exp[7:0] == 8'd0));
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, lo, hi;
    logic        z;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int nd;
    logic [2:0] o;
    logic [31:0] a, b;
    logic [63:0] r;

    tbl[0]  = '{OP_ADD,  32'hFFFFFFFF, 32'h1, 32'h0, 32'h1, 1'b1};
    tbl[1]  = '{OP_ADD,  32'h12345678, 32'h11111111, 32'h23456789, 32'h0, 1'b0};
    tbl[2]  = '{OP_SUB,  32'h5, 32'h7, 32'hFFFFFFFE, 32'h1, 1'b0};
    tbl[3]  = '{OP_SUB,  32'h7, 32'h7, 32'h0, 32'h0, 1'b1};
    tbl[4]  = '{OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 1'b0};
    tbl[5]  = '{OP_OR,   32'h12340000, 32'h00005678, 32'h12345678, 32'h0, 1'b0};
    tbl[6]  = '{OP_NAND, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1};
    tbl[7]  = '{OP_NOR,  32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0};
    tbl[8]  = '{OP_XOR,  32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'h0, 1'b0};
`ifdef SEQ_ALU_SIGNED_MULT_EN
    tbl[9]  = '{OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0};
`else
    tbl[9]  = '{OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 1'b0};
`endif
    tbl[10] = '{OP_MULT, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b1};

    #12;
    chk("rst/outs", {busy, done, zero, out, out_hi}, 67'd0);
    chk("rst/outs8", {s8_busy, s8_done, s8_zero, s8_out, s8_hi}, 19'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 11; i++)
      run32($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
            tbl[i].lo, tbl[i].hi, tbl[i].z);

    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 7));
      a = (i % 7 == 0) ? 32'hFFFFFFFF : $urandom;
      b = (i % 5 == 0) ? 32'h0 : $urandom;
      run32m($sformatf("rnd%0d", i), o, a, b);
    end

`ifdef SEQ_ALU_SIGNED_MULT_EN
    run8("w8mul", OP_MULT, 8'h80, 8'h02, 16'hFF00);
`else
    run8("w8mul", OP_MULT, 8'h80, 8'h02, 16'h0100);
`endif
    for (int i = 0; i < 10; i++) begin
      o = (i < 6) ? OP_MULT : 3'($urandom_range(0, 7));
      a = {24'd0, 8'($urandom)};
      b = {24'd0, 8'($urandom)};
      r = ref_res(o, 8, {32'd0, a}, {32'd0, b});
      run8($sformatf("w8r%0d", i), o, a[7:0], b[7:0], r[15:0]);
    end

    // ADD pulsed while MULT is busy must be dropped
    start = 1'b1; op = OP_MULT; inp1 = 32'd7; inp2 = 32'd6;
    @(posedge CLK); #1;
    start = 1'b0;
    nd = 0;
    for (int i = 1; i <= W + 4; i++) begin
      if (i == 5) begin
        start = 1'b1; op = OP_ADD; inp1 = 32'd1; inp2 = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge CLK); #1;
      if (done) begin
        nd++;
        if (nd == 1) chk("drop/res", {out_hi, out}, 64'd42);
      end
    end
    chk("drop/ndone", nd, 1);

    // reset mid-MULT aborts with outputs cleared
    start = 1'b1; op = OP_MULT; inp1 = 32'd3; inp2 = 32'd5;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    chk("abort/outs", {busy, done, zero, out, out_hi}, 67'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    nd = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge CLK); #1;
      if (done) nd++;
    end
    chk("abort/ndone", nd, 0);
    run32("sub57", OP_SUB, 32'd5, 32'd7, 32'hFFFFFFFE, 32'h1, 1'b0);

    // start held high: AND, XOR, MULT, OR back to back
    start = 1'b1; op = OP_AND; inp1 = 32'hF0F0F0F0; inp2 = 32'hFF00FF00;
    @(posedge CLK); #1;
    chk("b2b/and", {done, out}, {1'b1, 32'hF000F000});
    op = OP_XOR; inp1 = 32'h0000FFFF; inp2 = 32'h00FF00FF;
    @(posedge CLK); #1;
    chk("b2b/xor", {done, out}, {1'b1, 32'h00FFFF00});
    op = OP_MULT; inp1 = 32'd123; inp2 = 32'd1000;
    @(posedge CLK); #1;
    chk("b2b/macc", {busy, done}, 2'b10);
    op = OP_OR; inp1 = 32'h00000F00; inp2 = 32'h000000F0;
    nd = 1;
    while (!done && nd < W + 8) begin
      @(posedge CLK); #1;
      nd++;
    end
    chk("b2b/mlat", nd, W + 1);
    chk("b2b/mres", {busy, out_hi, out}, {1'b0, 32'd0, 32'd123000});
    @(posedge CLK); #1;
    start = 1'b0;
    chk("b2b/or", {done, busy, out_hi, out}, {2'b10, 32'd0, 32'h00000FF0});
    @(posedge CLK); #1;
    chk("b2b/idle", {done, busy}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
